mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port, byte-addressed test memory between the core's instruction-fetch (I) and load/store (D) ports.
//  Round-robin arbitration on conflict. Sub-word stores become read-modify-write, since the memory always writes 32 bits.
//  Watches tohost, stops all traffic when it goes nonzero, and reports pass/fail plus a cycle count.
// PARAMETERS
//  PASS_CODE  8'h01  tohost value that means the test passed
// PORTS
//  clk           in   1   single clock; all state updates on rising edge
//  rst           in   1   synchronous, active-high reset
//  i_req         in   1   fetch request; held with i_addr until i_ready
//  i_addr        in   32  fetch byte address
//  i_ready       out  1   fetch accepted (one-cycle pulse)
//  i_rvalid      out  1   i_rdata valid (one-cycle pulse)
//  i_rdata       out  32  fetched word
//  d_req         in   1   data request; held with d_* until d_ready
//  d_we          in   1   1 = store, 0 = load
//  d_addr        in   32  data byte address
//  d_wdata       in   32  store data, lane-aligned
//  d_wstrb       in   4   store byte enables; bit n -> bits [8n+7:8n]
//  d_ready       out  1   data accepted (one-cycle pulse)
//  d_rvalid      out  1   load data valid / store ack (one-cycle pulse)
//  d_rdata       out  32  loaded word
//  mem_addr      out  32  word address to memory; {addr[31:2],2'b00}
//  mem_we        out  1   memory write enable, at most one cycle per write
//  mem_wdata     out  32  memory write word
//  mem_rdata     in   32  memory read word; combinational from mem_addr
//  tohost        in   8   memory tohost byte
//  halt          out  1   test finished; no further grants
//  pass          out  1   tohost == PASS_CODE at halt entry
//  cycle_count   out  32  cycles since reset; frozen once halted
// BEHAVIOUR
//  States: IDLE, I_RD, D_RD, D_WR, D_RMW_RD, D_RMW_WR, HALT. Reset puts FSM in IDLE.
//  Reset values: all outputs 0; rr_last=D, so I wins the first conflict; data registers 0.
//  Decide point: every cycle in IDLE, and the last cycle of each serve state.
//   - tohost!=0 -> HALT; latch pass.
//   - else only i_req -> I_RD; only d_req -> D path; both -> the port other than rr_last.
//   - else neither -> IDLE.
//  D path: !d_we -> D_RD; d_we && (wstrb==4'hF or 4'h0) -> D_WR; other strobe -> D_RMW_RD.
//  I_RD (1 cyc): mem_addr=i_addr aligned; i_ready=1; mem_rdata -> i_rdata reg; i_rvalid=1 next cycle; rr_last<=I.
//  D_RD (1 cyc): same on the D port; rr_last<=D.
//  D_WR (1 cyc): mem_we = (wstrb!=0); mem_wdata=d_wdata; d_ready=1; d_rvalid next cycle; d_rdata unchanged.
//  D_RMW_RD (1 cyc): read word at d_addr; merge[n] = wstrb[n] ? d_wdata lane : mem_rdata lane; no ready.
//  D_RMW_WR (1 cyc): mem_we=1, mem_wdata=merge, d_ready=1; d_rvalid next cycle; rr_last<=D.
//  Latency: grant-to-rvalid is 1 cycle; request-to-ready is >=1 cycle (IDLE decide cycle), 0 extra when chained back-to-back.
//  Decide points outside IDLE go straight to the next serve state with no IDLE bubble.
//  mem_we is 0 in every state except D_WR/D_RMW_WR. mem_addr holds its last value in IDLE/HALT.
//  tohost nonzero mid-RMW: finish D_RMW_WR, then HALT. No partial write ever occurs.
//  HALT: absorbing until rst. halt=1, all ready/rvalid/mem_we 0, pass held, cycle_count frozen.
//  A final rvalid owed from the last serve cycle is still delivered in the first HALT cycle.
//  cycle_count: +1 per cycle while not in HALT; wraps at 2^32.
//  Dropping a request before ready: undefined for the requester. The arbiter samples only at decide points.
//  rst asserted mid-transaction: abort immediately, no write issued in the reset cycle, all state to reset values.
// TESTING
//  1. i_req only, i_addr=0x80000004, mem word 0x00100093 -> i_ready cycle 2, i_rvalid cycle 3, i_rdata=0x00100093.
//  2. i_req & d_req (load) same cycle from reset -> I served first, D next cycle; repeat with both held -> grants alternate I,D,I,D.
//  3. Store wstrb=4'b0010, wdata=0x0000AB00 to word 0x11223344 -> 2-cycle RMW; memory=0x1122AB44; one mem_we pulse.
//  4. Store wstrb=4'hF, 0xDEADBEEF -> single D_WR cycle writes 0xDEADBEEF; wstrb=0 -> ack with mem_we=0, memory unchanged.
//  5. tohost=0x01 during RMW -> RMW completes, then halt=1, pass=1, cycle_count frozen; tohost=0x03 -> pass=0; later requests never get ready.
//  6. rst in D_RMW_RD cycle -> no mem_we, FSM IDLE, outputs 0, cycle_count=0 next cycle.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core's fetch/data ports, the arbiter and the single-port test memory.
// The slave modport is the arbiter's view; the master modport is the core-plus-memory side.
interface mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ready;
    logic        i_rvalid;
    logic [31:0] i_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_ready;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
        output i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata,
        output mem_addr, mem_we, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
        input  i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata,
        input  mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one word-wide memory between fetch and load/store ports.
// Sub-word stores become read-modify-write; a nonzero tohost halts all traffic and reports pass/fail.
module mem_arbiter #(
    parameter logic [7:0] PASS_CODE = 8'h01
) (
    input  logic               clk,
    input  logic               rst,
    mem_arbiter_if.slave       bus,
    input  logic [7:0]         tohost,
    output logic               halt,
    output logic               pass,
    output logic [31:0]        cycle_count
);

    typedef enum logic [2:0] {
        StIdle, StIRd, StDRd, StDWr, StDRmwRd, StDRmwWr, StHalt
    } state_e;

    typedef enum logic {PortI, PortD} port_e;

    state_e      state_q;
    port_e       rr_last_q;
    logic        i_ready_q, i_rvalid_q, d_ready_q, d_rvalid_q, mem_we_q;
    logic [31:0] i_rdata_q, d_rdata_q, mem_addr_q, mem_wdata_q;
    logic        halt_q, pass_q;
    logic [31:0] cycle_q;

    logic        decide, excl_i, excl_d, want_i, want_d, pick_i, pick_d;
    logic [31:0] merge;

    always_comb begin
        decide = 1'b0;
        excl_i = 1'b0;
        excl_d = 1'b0;
        // The port acknowledged this cycle still shows its old request; keep it out of the decision.
        unique case (state_q)
            StIdle:                   decide = 1'b1;
            StIRd:                    begin decide = 1'b1; excl_i = 1'b1; end
            StDRd, StDWr, StDRmwWr:   begin decide = 1'b1; excl_d = 1'b1; end
            default:                  decide = 1'b0;
        endcase
        want_i = bus.i_req && !excl_i;
        want_d = bus.d_req && !excl_d;
        pick_i = want_i && (!want_d || (rr_last_q == PortD));
        pick_d = want_d && !pick_i;
        merge  = '0;
        for (int n = 0; n < 4; n++) begin
            merge[8*n +: 8] = bus.d_wstrb[n] ? bus.d_wdata[8*n +: 8] : bus.mem_rdata[8*n +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            rr_last_q   <= PortD;
            i_ready_q   <= 1'b0;
            i_rvalid_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            d_rvalid_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            halt_q      <= 1'b0;
            pass_q      <= 1'b0;
            cycle_q     <= '0;
        end else begin
            i_ready_q  <= 1'b0;
            i_rvalid_q <= 1'b0;
            d_ready_q  <= 1'b0;
            d_rvalid_q <= 1'b0;
            mem_we_q   <= 1'b0;
            if (state_q != StHalt) cycle_q <= cycle_q + 32'd1;

            unique case (state_q)
                StIRd: begin
                    i_rvalid_q <= 1'b1;
                    i_rdata_q  <= bus.mem_rdata;
                end
                StDRd: begin
                    d_rvalid_q <= 1'b1;
                    d_rdata_q  <= bus.mem_rdata;
                end
                StDWr, StDRmwWr: d_rvalid_q <= 1'b1;
                StDRmwRd: begin
                    mem_we_q    <= 1'b1;
                    mem_wdata_q <= merge;
                    d_ready_q   <= 1'b1;
                    state_q     <= StDRmwWr;
                end
                default: ;
            endcase

            if (decide) begin
                if (tohost != 8'h00) begin
                    state_q <= StHalt;
                    halt_q  <= 1'b1;
                    pass_q  <= (tohost == PASS_CODE);
                end else if (pick_i) begin
                    state_q    <= StIRd;
                    i_ready_q  <= 1'b1;
                    mem_addr_q <= {bus.i_addr[31:2], 2'b00};
                    rr_last_q  <= PortI;
                end else if (pick_d) begin
                    mem_addr_q <= {bus.d_addr[31:2], 2'b00};
                    rr_last_q  <= PortD;
                    if (!bus.d_we) begin
                        state_q   <= StDRd;
                        d_ready_q <= 1'b1;
                    end else if (bus.d_wstrb == 4'hF || bus.d_wstrb == 4'h0) begin
                        // An all-zero strobe is acknowledged without touching memory.
                        state_q     <= StDWr;
                        d_ready_q   <= 1'b1;
                        mem_we_q    <= |bus.d_wstrb;
                        mem_wdata_q <= bus.d_wdata;
                    end else begin
                        state_q <= StDRmwRd;
                    end
                end else begin
                    state_q <= StIdle;
                end
            end
        end
    end

    assign bus.i_ready   = i_ready_q;
    assign bus.i_rvalid  = i_rvalid_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign halt          = halt_q;
    assign pass          = pass_q;
    assign cycle_count   = cycle_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a small word memory model behind the arbiter,
// one task per scenario with hand-computed expectations.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  tohost;
    logic        halt, pass;
    logic [31:0] cycle_count;

    mem_arbiter_if bus ();

    mem_arbiter #(.PASS_CODE(8'h01)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .tohost      (tohost),
        .halt        (halt),
        .pass        (pass),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [64];
    int          we_count;
    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [31:0] pl_data;

    assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
            we_count <= we_count + 1;
        end else if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end
    end

    int tests, fails, tb_cycles;

    task automatic tick();
        @(posedge clk);
        #1;
        tb_cycles++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tb_cycles = 0;
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] data);
        pl_en = 1'b1; pl_idx = idx; pl_data = data;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.i_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
        bus.i_addr = '0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wstrb = '0;
    endtask

    task automatic test_reset();
        logic [31:0] all_ctl;
        do_reset();
        all_ctl = {22'd0, bus.i_ready, bus.i_rvalid, bus.d_ready, bus.d_rvalid, bus.mem_we,
                   halt, pass, 3'd0};
        tests++;
        if (all_ctl !== 32'd0) begin
            $display("FAIL reset_ctl got %h want 0", all_ctl); fails++;
        end
        tests++;
        if ({bus.mem_addr, bus.i_rdata, bus.d_rdata, cycle_count} !== 128'd0) begin
            $display("FAIL reset_data got %h %h %h %h want 0", bus.mem_addr, bus.i_rdata,
                     bus.d_rdata, cycle_count); fails++;
        end
    endtask

    task automatic test_fetch();
        bus.i_req = 1'b1; bus.i_addr = 32'h8000_0004;
        tick();
        tests++;
        if (bus.i_ready !== 1'b1 || bus.i_rvalid !== 1'b0) begin
            $display("FAIL fetch_ready got rdy=%b rv=%b want 1 0", bus.i_ready, bus.i_rvalid);
            fails++;
        end
        tests++;
        if (bus.mem_addr !== 32'h8000_0004) begin
            $display("FAIL fetch_addr got %h want 80000004", bus.mem_addr); fails++;
        end
        tick();
        bus.i_req = 1'b0;
        tests++;
        if (bus.i_rvalid !== 1'b1 || bus.i_ready !== 1'b0 || bus.i_rdata !== 32'h0010_0093) begin
            $display("FAIL fetch_data got rv=%b rdy=%b data=%h want 1 0 00100093",
                     bus.i_rvalid, bus.i_ready, bus.i_rdata); fails++;
        end
        tests++;
        if (cycle_count !== tb_cycles) begin
            $display("FAIL fetch_cycles got %0d want %0d", cycle_count, tb_cycles); fails++;
        end
    endtask

    task automatic test_conflict();
        logic [3:0] gi, gd;
        do_reset();
        bus.i_req = 1'b1; bus.i_addr = 32'h8000_0004;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h8000_0010;
        for (int k = 0; k < 4; k++) begin
            tick();
            gi[k] = bus.i_ready;
            gd[k] = bus.d_ready;
            if (k == 2) begin
                tests++;
                if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hCAFE_F00D) begin
                    $display("FAIL conflict_load got rv=%b data=%h want 1 cafef00d",
                             bus.d_rvalid, bus.d_rdata); fails++;
                end
            end
        end
        tests++;
        if (gi !== 4'b0101 || gd !== 4'b1010) begin
            $display("FAIL conflict_order got i=%b d=%b want 0101 1010", gi, gd); fails++;
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        tick();
        tests++;
        if (bus.d_rvalid !== 1'b1 || bus.i_ready !== 1'b0 || bus.d_ready !== 1'b0) begin
            $display("FAIL conflict_drain got rv=%b irdy=%b drdy=%b want 1 0 0",
                     bus.d_rvalid, bus.i_ready, bus.d_ready); fails++;
        end
    endtask

    task automatic test_rmw();
        int we0;
        we0 = we_count;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h8000_0021;
        bus.d_wdata = 32'h0000_AB00; bus.d_wstrb = 4'b0010;
        tick();
        tests++;
        if (bus.d_ready !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h8000_0020) begin
            $display("FAIL rmw_rd got rdy=%b we=%b addr=%h want 0 0 80000020",
                     bus.d_ready, bus.mem_we, bus.mem_addr); fails++;
        end
        tick();
        bus.d_req = 1'b0;
        tests++;
        if (bus.d_ready !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_wdata !== 32'h1122_AB44) begin
            $display("FAIL rmw_wr got rdy=%b we=%b wdata=%h want 1 1 1122ab44",
                     bus.d_ready, bus.mem_we, bus.mem_wdata); fails++;
        end
        tick();
        tests++;
        if (bus.d_rvalid !== 1'b1 || mem[8] !== 32'h1122_AB44 || we_count - we0 != 1) begin
            $display("FAIL rmw_done got rv=%b mem=%h writes=%0d want 1 1122ab44 1",
                     bus.d_rvalid, mem[8], we_count - we0); fails++;
        end
    endtask

    task automatic test_full_store();
        int we0;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h8000_0030;
        bus.d_wdata = 32'hDEAD_BEEF; bus.d_wstrb = 4'hF;
        tick();
        bus.d_req = 1'b0;
        tests++;
        if (bus.d_ready !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_wdata !== 32'hDEAD_BEEF) begin
            $display("FAIL store_full got rdy=%b we=%b wdata=%h want 1 1 deadbeef",
                     bus.d_ready, bus.mem_we, bus.mem_wdata); fails++;
        end
        tick();
        tests++;
        if (bus.d_rvalid !== 1'b1 || mem[12] !== 32'hDEAD_BEEF) begin
            $display("FAIL store_full_ack got rv=%b mem=%h want 1 deadbeef", bus.d_rvalid, mem[12]);
            fails++;
        end
        we0 = we_count;
        bus.d_req = 1'b1; bus.d_wdata = 32'h1234_5678; bus.d_wstrb = 4'h0;
        tick();
        bus.d_req = 1'b0;
        tests++;
        if (bus.d_ready !== 1'b1 || bus.mem_we !== 1'b0) begin
            $display("FAIL store_zero got rdy=%b we=%b want 1 0", bus.d_ready, bus.mem_we); fails++;
        end
        tick();
        tests++;
        if (bus.d_rvalid !== 1'b1 || mem[12] !== 32'hDEAD_BEEF || we_count != we0
            || bus.d_rdata !== 32'hCAFE_F00D) begin
            $display("FAIL store_zero_ack got rv=%b mem=%h writes=%0d rdata=%h want 1 deadbeef 0 cafef00d",
                     bus.d_rvalid, mem[12], we_count - we0, bus.d_rdata); fails++;
        end
    endtask

    task automatic test_halt();
        logic [31:0] frozen;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h8000_0040;
        bus.d_wdata = 32'h0000_00EE; bus.d_wstrb = 4'b0001;
        tick();
        tohost = 8'h01;
        bus.i_req = 1'b1; bus.i_addr = 32'h8000_0004;
        tick();
        bus.d_req = 1'b0;
        tests++;
        if (bus.mem_we !== 1'b1 || halt !== 1'b0) begin
            $display("FAIL halt_rmw_wr got we=%b halt=%b want 1 0", bus.mem_we, halt); fails++;
        end
        tick();
        tests++;
        if (halt !== 1'b1 || pass !== 1'b1 || bus.d_rvalid !== 1'b1 || mem[16] !== 32'hAAAA_AAEE) begin
            $display("FAIL halt_entry got halt=%b pass=%b rv=%b mem=%h want 1 1 1 aaaaaaee",
                     halt, pass, bus.d_rvalid, mem[16]); fails++;
        end
        tests++;
        if (cycle_count !== tb_cycles) begin
            $display("FAIL halt_cycles got %0d want %0d", cycle_count, tb_cycles); fails++;
        end
        frozen = tb_cycles;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++;
            if (bus.i_ready !== 1'b0 || bus.mem_we !== 1'b0 || cycle_count !== frozen || halt !== 1'b1) begin
                $display("FAIL halt_hold got rdy=%b we=%b cc=%0d halt=%b want 0 0 %0d 1",
                         bus.i_ready, bus.mem_we, cycle_count, halt, frozen); fails++;
            end
        end
        bus.i_req = 1'b0;
        tohost = 8'h03;
        do_reset();
        tests++;
        if (halt !== 1'b0) begin
            $display("FAIL halt_cleared got %b want 0", halt); fails++;
        end
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h8000_0010;
        tick();
        tick();
        tests++;
        if (halt !== 1'b1 || pass !== 1'b0 || bus.d_ready !== 1'b0) begin
            $display("FAIL halt_failcode got halt=%b pass=%b rdy=%b want 1 0 0", halt, pass, bus.d_ready);
            fails++;
        end
        bus.d_req = 1'b0;
        tohost = 8'h00;
    endtask

    task automatic test_reset_mid_rmw();
        int we0;
        do_reset();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h8000_0050;
        bus.d_wdata = 32'h00CC_0000; bus.d_wstrb = 4'b0100;
        tick();
        we0 = we_count;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.d_req = 1'b0;
        tests++;
        if (bus.mem_we !== 1'b0 || bus.d_ready !== 1'b0 || bus.mem_addr !== 32'd0
            || cycle_count !== 32'd0 || halt !== 1'b0) begin
            $display("FAIL rst_mid_rmw got we=%b rdy=%b addr=%h cc=%0d halt=%b want 0 0 0 0 0",
                     bus.mem_we, bus.d_ready, bus.mem_addr, cycle_count, halt); fails++;
        end
        tick();
        tests++;
        if (mem[20] !== 32'h5555_5555 || we_count != we0 || bus.d_rvalid !== 1'b0) begin
            $display("FAIL rst_no_write got mem=%h writes=%0d rv=%b want 55555555 0 0",
                     mem[20], we_count - we0, bus.d_rvalid); fails++;
        end
    endtask

    initial begin
        tests = 0; fails = 0; tb_cycles = 0; we_count = 0;
        pl_en = 1'b0; pl_idx = '0; pl_data = '0;
        tohost = 8'h00;
        idle_inputs();
        rst = 1'b1;
        preload(6'd1,  32'h0010_0093);
        preload(6'd4,  32'hCAFE_F00D);
        preload(6'd8,  32'h1122_3344);
        preload(6'd12, 32'h0000_0000);
        preload(6'd16, 32'hAAAA_AAAA);
        preload(6'd20, 32'h5555_5555);
        test_reset();
        test_fetch();
        test_conflict();
        test_rmw();
        test_full_store();
        test_halt();
        test_reset_mid_rmw();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
